pong_ball_ctrl: RTL and testbench



---
 rtl/pong_ball_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
//   Ball motion controller for the pong datapath. Owns the ball position and
//   the two direction bits. The ball advances once per frame tick, bounces off
//   the top and bottom walls, and is returned by the paddles. A miss scores a
//   point. The block sequences the serve, play, point-hold and game-over phases.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   in_frame_tick  one-cycle pulse per video frame
//   in_serve       serve / restart request (level or pulse)
//   in_paddle_l_y  left paddle top y
//   in_paddle_r_y  right paddle top y
//   out_ball_x/y   ball left x / top y
//   out_dir_x      0 = moving right (+x), 1 = moving left (-x)
//   out_dir_y      0 = moving down (+y), 1 = moving up (-y)
//   out_score_l/r  player scores, saturating at 15
//   out_point      one-cycle pulse when a point is awarded
//   out_state      0 IDLE, 1 MOVE, 2 SCORED, 3 OVER
//
// Build option
//   SPEEDUP_EN  when defined, each paddle hit adds one pixel to the step, up to
//               MAX_STEP. The step returns to STEP on every point.
//
// state  | meaning
// IDLE   | ball centred, waiting for serve
// MOVE   | ball in play, one move per frame tick
// SCORED | ball frozen for HOLD_FRAMES ticks after a point
// OVER   | a player reached WIN_SCORE, waiting for serve to restart

module pong_ball_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL        = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PL_X        = 16,
  parameter int PR_X        = 616,
  parameter int STEP        = 2,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9,
  parameter int MAX_STEP    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_frame_tick,
  input  logic       in_serve,
  input  logic [9:0] in_paddle_l_y,
  input  logic [9:0] in_paddle_r_y,
  output logic [9:0] out_ball_x,
  output logic [9:0] out_ball_y,
  output logic       out_dir_x,
  output logic       out_dir_y,
  output logic [3:0] out_score_l,
  output logic [3:0] out_score_r,
  output logic       out_point,
  output logic [1:0] out_state
);

  localparam int X_C    = (SCREEN_W - BALL) / 2;
  localparam int Y_C    = (SCREEN_H - BALL) / 2;
  localparam int Y_MAX  = SCREEN_H - BALL;
  localparam int X_R    = PR_X - BALL;
  localparam int X_L    = PL_X + PADDLE_W;
  localparam int STEP_W = $clog2(MAX_STEP + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_SCORED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic              point_q, point_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [STEP_W-1:0] step;

  // Candidate next position for a move tick, all in 11-bit unsigned space.
  logic [10:0] x_ext, y_ext, step_ext;
  logic [9:0]  x_nxt, y_nxt;
  logic        dir_x_nxt, dir_y_nxt;
  logic        miss_l, miss_r;
  logic        overlap_l, overlap_r;

  always_comb begin
    x_ext    = {1'b0, ball_x_q};
    y_ext    = {1'b0, ball_y_q};
    step_ext = 11'(step);

    // Paddle overlap uses the y before this tick's update.
    overlap_l = (11'(in_paddle_l_y) < y_ext + 11'(BALL)) &&
                (y_ext < 11'(in_paddle_l_y) + 11'(PADDLE_H));
    overlap_r = (11'(in_paddle_r_y) < y_ext + 11'(BALL)) &&
                (y_ext < 11'(in_paddle_r_y) + 11'(PADDLE_H));

    y_nxt     = ball_y_q;
    dir_y_nxt = dir_y_q;
    if (!dir_y_q) begin
      if (y_ext + step_ext >= 11'(Y_MAX)) begin
        y_nxt     = 10'(Y_MAX);
        dir_y_nxt = 1'b1;
      end else begin
        y_nxt = 10'(y_ext + step_ext);
      end
    end else begin
      if (y_ext <= step_ext) begin
        y_nxt     = '0;
        dir_y_nxt = 1'b0;
      end else begin
        y_nxt = 10'(y_ext - step_ext);
      end
    end

    x_nxt     = ball_x_q;
    dir_x_nxt = dir_x_q;
    miss_l    = 1'b0;
    miss_r    = 1'b0;
    if (!dir_x_q) begin
      if (x_ext + step_ext >= 11'(X_R)) begin
        x_nxt = 10'(X_R);
        if (overlap_r) dir_x_nxt = 1'b1;
        else           miss_r    = 1'b1;
      end else begin
        x_nxt = 10'(x_ext + step_ext);
      end
    end else begin
      if (x_ext <= 11'(X_L) + step_ext) begin
        x_nxt = 10'(X_L);
        if (overlap_l) dir_x_nxt = 1'b0;
        else           miss_l    = 1'b1;
      end else begin
        x_nxt = 10'(x_ext - step_ext);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    point_d   = 1'b0;
    hold_d    = hold_q;

    case (state_q)
      S_IDLE: begin
        if (in_serve) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (in_frame_tick) begin
          ball_x_d = x_nxt;
          ball_y_d = y_nxt;
          dir_x_d  = dir_x_nxt;
          dir_y_d  = dir_y_nxt;
          if (miss_r) score_l_d = (score_l_q == 4'hF) ? 4'hF : score_l_q + 4'd1;
          if (miss_l) score_r_d = (score_r_q == 4'hF) ? 4'hF : score_r_q + 4'd1;
          if (miss_l || miss_r) begin
            point_d = 1'b1;
            hold_d  = HOLD_W'(HOLD_FRAMES);
            state_d = S_SCORED;
          end
        end
      end
      S_SCORED: begin
        if (in_frame_tick) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_d = '0;
            if (score_l_q == 4'(WIN_SCORE) || score_r_q == 4'(WIN_SCORE)) begin
              state_d = S_OVER;
            end else begin
              state_d  = S_IDLE;
              ball_x_d = 10'(X_C);
              ball_y_d = 10'(Y_C);
            end
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      S_OVER: begin
        if (in_serve) begin
          state_d   = S_IDLE;
          score_l_d = '0;
          score_r_d = '0;
          ball_x_d  = 10'(X_C);
          ball_y_d  = 10'(Y_C);
          dir_x_d   = 1'b0;
          dir_y_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ball_x_q  <= 10'(X_C);
      ball_y_q  <= 10'(Y_C);
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      point_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_q   <= point_d;
      hold_q    <= hold_d;
    end
  end

`ifdef SPEEDUP_EN
  logic [STEP_W-1:0] step_q, step_d;

  // A paddle hit is the only event that flips dir_x during a move tick.
  always_comb begin
    step_d = step_q;
    if (state_q == S_MOVE && in_frame_tick) begin
      if (miss_l || miss_r)
        step_d = STEP_W'(STEP);
      else if (dir_x_nxt != dir_x_q)
        step_d = (step_q >= STEP_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : step_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) step_q <= STEP_W'(STEP);
    else       step_q <= step_d;
  end

  assign step = step_q;
`else
  assign step = STEP_W'(STEP);
`endif

  assign out_ball_x  = ball_x_q;
  assign out_ball_y  = ball_y_q;
  assign out_dir_x   = dir_x_q;
  assign out_dir_y   = dir_y_q;
  assign out_score_l = score_l_q;
  assign out_score_r = score_r_q;
  assign out_point   = point_q;
  assign out_state   = state_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
module tb_pong_ball_ctrl;

`ifdef SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk, reset, in_frame_tick, in_serve;
  logic [9:0] in_paddle_l_y, in_paddle_r_y;
  logic [9:0] out_ball_x, out_ball_y;
  logic       out_dir_x, out_dir_y, out_point;
  logic [3:0] out_score_l, out_score_r;
  logic [1:0] out_state;

  pong_ball_ctrl dut (
    .clk(clk), .reset(reset), .in_frame_tick(in_frame_tick), .in_serve(in_serve),
    .in_paddle_l_y(in_paddle_l_y), .in_paddle_r_y(in_paddle_r_y),
    .out_ball_x(out_ball_x), .out_ball_y(out_ball_y),
    .out_dir_x(out_dir_x), .out_dir_y(out_dir_y),
    .out_score_l(out_score_l), .out_score_r(out_score_r),
    .out_point(out_point), .out_state(out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed output vector: x, y, dir_x, dir_y, score_l, score_r, point, state
  logic [32:0] dut_vec;
  assign dut_vec = {out_ball_x, out_ball_y, out_dir_x, out_dir_y,
                    out_score_l, out_score_r, out_point, out_state};

  logic [32:0] exp_q[$];
  logic [32:0] exp;

  // Reference model, cycle level, integer arithmetic
  int m_state, m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_pt, m_hold, m_step;

  task automatic model_init();
    m_state = 0; m_x = 316; m_y = 236; m_dx = 0; m_dy = 0;
    m_sl = 0; m_sr = 0; m_pt = 0; m_hold = 0; m_step = 2;
  endtask

  task automatic model_clock(input bit tick, input bit serve, input bit rst);
    int ny, ndy, nx, ndx, pl, pr;
    bit hit, miss;
    pl = int'(in_paddle_l_y);
    pr = int'(in_paddle_r_y);
    m_pt = 0;
    if (rst) begin
      model_init();
    end else begin
      case (m_state)
        0: if (serve) m_state = 1;
        1: if (tick) begin
          if (m_dy == 0) begin
            if (m_y + m_step >= 472) begin ny = 472; ndy = 1; end
            else begin ny = m_y + m_step; ndy = 0; end
          end else begin
            if (m_y <= m_step) begin ny = 0; ndy = 0; end
            else begin ny = m_y - m_step; ndy = 1; end
          end
          hit = 0; miss = 0; nx = m_x; ndx = m_dx;
          if (m_dx == 0) begin
            if (m_x + m_step >= 608) begin
              nx = 608;
              if (pr < m_y + 8 && m_y < pr + 64) begin ndx = 1; hit = 1; end
              else begin miss = 1; m_sl = (m_sl >= 15) ? 15 : m_sl + 1; end
            end else nx = m_x + m_step;
          end else begin
            if (m_x <= 24 + m_step) begin
              nx = 24;
              if (pl < m_y + 8 && m_y < pl + 64) begin ndx = 0; hit = 1; end
              else begin miss = 1; m_sr = (m_sr >= 15) ? 15 : m_sr + 1; end
            end else nx = m_x - m_step;
          end
          m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
          if (miss) begin
            m_pt = 1; m_state = 2; m_hold = 0; m_step = 2;
          end else if (hit && SPEEDUP) begin
            m_step = (m_step + 1 > 6) ? 6 : m_step + 1;
          end
        end
        2: if (tick) begin
          m_hold++;
          if (m_hold == 60) begin
            m_hold = 0;
            if (m_sl == 9 || m_sr == 9) m_state = 3;
            else begin m_state = 0; m_x = 316; m_y = 236; end
          end
        end
        default: if (serve) begin
          m_sl = 0; m_sr = 0; m_x = 316; m_y = 236; m_dx = 0; m_dy = 0; m_state = 0;
        end
      endcase
    end
  endtask

  function automatic logic [32:0] model_vec();
    return {10'(m_x), 10'(m_y), 1'(m_dx), 1'(m_dy), 4'(m_sl), 4'(m_sr), 1'(m_pt), 2'(m_state)};
  endfunction

  // One clock with the given inputs; the expected result is queued at the edge.
  task automatic clk_step(input bit tick, input bit serve, input bit rst);
    in_frame_tick = tick;
    in_serve      = serve;
    reset         = rst;
    @(posedge clk);
    model_clock(tick, serve, rst);
    exp_q.push_back(model_vec());
    #1;
  endtask

  task automatic test_reset();
    clk_step(0, 0, 1);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL reset got=%h exp=%h", dut_vec, exp); end
    checks++;
    if (out_ball_x !== 10'd316 || out_ball_y !== 10'd236 || out_state !== 2'd0 || out_point !== 1'b0) begin
      failures++; $display("FAIL reset_values got x=%0d y=%0d st=%0d pt=%0d exp x=316 y=236 st=0 pt=0",
                           out_ball_x, out_ball_y, out_state, out_point);
    end
    for (int i = 0; i < 10; i++) begin
      clk_step(1, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL idle_tick got=%h exp=%h", dut_vec, exp); end
      clk_step(0, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL idle_gap got=%h exp=%h", dut_vec, exp); end
    end
    checks++;
    if (out_ball_x !== 10'd316 || out_ball_y !== 10'd236 || out_dir_x !== 1'b0 || out_dir_y !== 1'b0 ||
        out_score_l !== 4'd0 || out_score_r !== 4'd0 || out_state !== 2'd0) begin
      failures++; $display("FAIL idle_hold got=%h exp x=316 y=236 dirs=0 scores=0 st=0", dut_vec);
    end
  endtask

  task automatic test_serve();
    clk_step(0, 0, 1);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL serve_reset got=%h exp=%h", dut_vec, exp); end
    clk_step(1, 1, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp || out_state !== 2'd1 || out_ball_x !== 10'd316) begin
      failures++; $display("FAIL serve_with_tick got=%h exp=%h (st=1 x=316)", dut_vec, exp);
    end
    clk_step(1, 0, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp || out_ball_x !== 10'd318 || out_ball_y !== 10'd238) begin
      failures++; $display("FAIL first_move got=%h exp=%h (x=318 y=238)", dut_vec, exp);
    end
    clk_step(0, 1, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL serve_in_move got=%h exp=%h", dut_vec, exp); end
    clk_step(1, 1, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp || out_state !== 2'd1 || out_ball_x !== 10'd320) begin
      failures++; $display("FAIL serve_tick_in_move got=%h exp=%h (st=1 x=320)", dut_vec, exp);
    end
  endtask

  task automatic test_paddle_hit();
    in_paddle_r_y = 10'd400;
    in_paddle_l_y = 10'd0;
    clk_step(0, 0, 1);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL hit_reset got=%h exp=%h", dut_vec, exp); end
    clk_step(0, 1, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL hit_serve got=%h exp=%h", dut_vec, exp); end
    for (int t = 1; t <= 447; t++) begin
      if (t > 147) in_paddle_l_y = 10'(m_y);
      clk_step(1, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL hit_tick%0d got=%h exp=%h", t, dut_vec, exp); end
      if (t == 118) begin
        checks++;
        if (out_ball_y !== 10'd472 || out_dir_y !== 1'b1) begin
          failures++; $display("FAIL bottom_bounce got y=%0d dy=%0d exp y=472 dy=1", out_ball_y, out_dir_y);
        end
      end
      if (t == 146) begin
        checks++;
        if (out_ball_x !== 10'd608 || out_ball_y !== 10'd416 || out_dir_x !== 1'b1 ||
            out_point !== 1'b0 || out_score_l !== 4'd0) begin
          failures++; $display("FAIL right_hit got=%h exp x=608 y=416 dx=1 pt=0 sl=0", dut_vec);
        end
      end
      if (t == 147) begin
        checks++;
        if (out_ball_x !== (SPEEDUP ? 10'd605 : 10'd606)) begin
          failures++; $display("FAIL post_hit_step got x=%0d exp x=%0d", out_ball_x, SPEEDUP ? 605 : 606);
        end
      end
      clk_step(0, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL hit_gap%0d got=%h exp=%h", t, dut_vec, exp); end
    end
    checks++;
    if (out_dir_x !== 1'b0 || out_score_r !== 4'd0 || out_state !== 2'd1) begin
      failures++; $display("FAIL left_paddle_return got dx=%0d sr=%0d st=%0d exp dx=0 sr=0 st=1",
                           out_dir_x, out_score_r, out_state);
    end
  endtask

  task automatic test_miss_and_hold();
    in_paddle_r_y = 10'd0;
    clk_step(0, 0, 1);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL miss_reset got=%h exp=%h", dut_vec, exp); end
    clk_step(0, 1, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL miss_serve got=%h exp=%h", dut_vec, exp); end
    for (int t = 1; t <= 146; t++) begin
      clk_step(1, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL miss_tick%0d got=%h exp=%h", t, dut_vec, exp); end
      if (t < 146) clk_step(0, 0, 0);
      if (t < 146) begin
        exp = exp_q.pop_front(); checks++;
        if (dut_vec !== exp) begin failures++; $display("FAIL miss_gap%0d got=%h exp=%h", t, dut_vec, exp); end
      end
    end
    checks++;
    if (out_point !== 1'b1 || out_score_l !== 4'd1 || out_state !== 2'd2 || out_ball_x !== 10'd608) begin
      failures++; $display("FAIL point_award got=%h exp pt=1 sl=1 st=2 x=608", dut_vec);
    end
    clk_step(0, 0, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp || out_point !== 1'b0) begin
      failures++; $display("FAIL point_pulse_width got=%h exp=%h (pt=0)", dut_vec, exp);
    end
    for (int h = 1; h <= 60; h++) begin
      clk_step(1, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL hold_tick%0d got=%h exp=%h", h, dut_vec, exp); end
      if (h == 59) begin
        checks++;
        if (out_state !== 2'd2) begin failures++; $display("FAIL hold_early got st=%0d exp st=2", out_state); end
      end
      clk_step(0, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL hold_gap%0d got=%h exp=%h", h, dut_vec, exp); end
    end
    checks++;
    if (out_state !== 2'd0 || out_ball_x !== 10'd316 || out_ball_y !== 10'd236 || out_dir_x !== 1'b0) begin
      failures++; $display("FAIL hold_release got=%h exp st=0 x=316 y=236 dx=0", dut_vec);
    end
  endtask

  task automatic test_game_over();
    clk_step(0, 0, 1);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL over_reset got=%h exp=%h", dut_vec, exp); end
    for (int i = 0; i < 3000 && out_state !== 2'd3; i++) begin
      // Keep the right paddle clear of the ball so every rally is a left point.
      in_paddle_r_y = (m_y >= 240) ? 10'd0 : 10'd400;
      clk_step(out_state != 2'd0, out_state == 2'd0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL over_run%0d got=%h exp=%h", i, dut_vec, exp); end
      clk_step(0, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL over_gap%0d got=%h exp=%h", i, dut_vec, exp); end
    end
    checks++;
    if (out_state !== 2'd3 || out_score_l !== 4'd9 || out_score_r !== 4'd0) begin
      failures++; $display("FAIL game_over got st=%0d sl=%0d sr=%0d exp st=3 sl=9 sr=0",
                           out_state, out_score_l, out_score_r);
    end
    for (int i = 0; i < 5; i++) begin
      clk_step(1, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp || out_ball_x !== 10'd608) begin
        failures++; $display("FAIL over_frozen got=%h exp=%h (x=608)", dut_vec, exp);
      end
    end
    clk_step(0, 1, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp || out_score_l !== 4'd0 || out_state !== 2'd0 || out_ball_x !== 10'd316 ||
        out_ball_y !== 10'd236) begin
      failures++; $display("FAIL over_restart got=%h exp=%h (sl=0 st=0 x=316 y=236)", dut_vec, exp);
    end
  endtask

  task automatic test_reset_mid_move();
    clk_step(0, 1, 0);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp) begin failures++; $display("FAIL mid_serve got=%h exp=%h", dut_vec, exp); end
    for (int i = 0; i < 20; i++) begin
      clk_step(1, 0, 0);
      exp = exp_q.pop_front(); checks++;
      if (dut_vec !== exp) begin failures++; $display("FAIL mid_tick%0d got=%h exp=%h", i, dut_vec, exp); end
    end
    clk_step(1, 0, 1);
    exp = exp_q.pop_front(); checks++;
    if (dut_vec !== exp || out_state !== 2'd0 || out_ball_x !== 10'd316 || out_ball_y !== 10'd236 ||
        out_dir_x !== 1'b0 || out_dir_y !== 1'b0 || out_score_l !== 4'd0) begin
      failures++; $display("FAIL mid_reset got=%h exp=%h", dut_vec, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_frame_tick = 1'b0; in_serve = 1'b0;
    in_paddle_l_y = 10'd0; in_paddle_r_y = 10'd0;
    model_init();
    test_reset();
    test_serve();
    test_paddle_hit();
    test_miss_and_hold();
    test_game_over();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
